// File: rtl/logic_clk_en_ctrl.sv
// Clock-enable controller for the JTAG-path logic clock gate: N-cycle bursts and free-run.
// Optional feature: define LOGIC_CLK_NEG_LATCH_EN to re-time clk_en on the falling edge of clk.
module logic_clk_en_ctrl #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] pulse_cnt,
    input  logic             abort,
    input  logic             freerun,
    output logic             clk_en,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] issued
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SETUP = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_nxt;
    logic             w_accept;
    logic             w_en_d;
    logic             r_en_q;
    logic             r_busy;
    logic             r_done;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_issued;

    // Next-state decode; a start is only honoured in IDLE with free-run off.
    always_comb begin
        w_nxt    = r_state;
        w_accept = 1'b0;
        w_en_d   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (start && !freerun) begin
                    w_accept = 1'b1;
                    if (pulse_cnt == '0) begin
                        w_nxt = S_DONE;
                    end else begin
                        w_nxt = S_SETUP;
                    end
                end
            end
            S_SETUP: begin
                if (abort) begin
                    w_nxt = S_DONE;
                end else begin
                    w_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (abort || (r_cnt == CNT_W'(1))) begin
                    w_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_nxt = S_IDLE;
            end
            default: begin
                w_nxt = S_IDLE;
            end
        endcase
        // Enable is open in every RUN cycle, or follows freerun one edge late while idle.
        w_en_d = (w_nxt == S_RUN) || ((r_state == S_IDLE) && freerun);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nxt;
        end
    end

    // Registered enable and handshake outputs, aligned with the state they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_en_q <= 1'b0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_en_q <= w_en_d;
            r_busy <= (w_nxt != S_IDLE);
            r_done <= (w_nxt == S_DONE);
        end
    end

    // Down-counter for the remaining burst and up-counter of cycles actually issued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_issued <= '0;
        end else if (w_accept) begin
            r_cnt    <= pulse_cnt;
            r_issued <= '0;
        end else if (r_state == S_RUN) begin
            r_cnt    <= r_cnt - CNT_W'(1);
            r_issued <= r_issued + CNT_W'(1);
        end
    end

`ifdef LOGIC_CLK_NEG_LATCH_EN
    logic r_en_n;

    // Re-time the enable on the falling edge so a plain AND gate never glitches.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_en_n <= 1'b0;
        end else begin
            r_en_n <= r_en_q;
        end
    end

    assign clk_en = r_en_n;
`else
    assign clk_en = r_en_q;
`endif

    assign busy   = r_busy;
    assign done   = r_done;
    assign issued = r_issued;

endmodule

// File: tb/tb_logic_clk_en_ctrl.sv
// Self-checking bench for logic_clk_en_ctrl: vector table, corner sequences, random vs model.
// Outputs are sampled 7 ns after each rising edge, after the falling edge in either build.
module tb_logic_clk_en_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] pulse_cnt;
    logic       abort;
    logic       freerun;
    logic       clk_en;
    logic       busy;
    logic       done;
    logic [7:0] issued;

    int n_cmp;
    int n_bad;
    int gcount;

    logic w_gclk;
    assign w_gclk = clk & clk_en;

    logic_clk_en_ctrl #(.CNT_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .pulse_cnt (pulse_cnt),
        .abort     (abort),
        .freerun   (freerun),
        .clk_en    (clk_en),
        .busy      (busy),
        .done      (done),
        .issued    (issued)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge w_gclk) gcount++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

`ifdef LOGIC_CLK_NEG_LATCH_EN
    always @(clk_en) begin
        if (rst_n === 1'b1) begin
            chk("clk_en_edge_while_clk_low", {31'd0, clk}, 32'd0);
        end
    end
`endif

    task automatic tick();
        @(posedge clk);
        #7;
    endtask

    task automatic drive(input logic s, input int n, input logic a, input logic f);
        start     = s;
        pulse_cnt = 8'(n);
        abort     = a;
        freerun   = f;
    endtask

    typedef struct {
        logic s;
        int   n;
        logic a;
        logic f;
        logic e;
        logic b;
        logic d;
        int   i;
    } vec_t;

    function automatic vec_t mk(logic s, int n, logic a, logic f,
                                logic e, logic b, logic d, int i);
        vec_t v;
        v.s = s; v.n = n; v.a = a; v.f = f;
        v.e = e; v.b = b; v.d = d; v.i = i;
        return v;
    endfunction

    typedef struct {
        logic en;
        logic dn;
    } ent_t;

    vec_t tv[21];

    initial begin
        int   en_cnt;
        int   dn_cnt;
        int   bz_cnt;
        int   iss_hold;
        ent_t q[$];
        ent_t cur;
        ent_t e;
        bit   cur_v;
        bit   prev_idle;
        int   m_iss;
        logic x_en;
        logic x_busy;
        logic x_done;
        logic r_s;
        logic r_a;
        logic r_f;
        int   r_n;

        n_cmp  = 0;
        n_bad  = 0;
        gcount = 0;

        tv[0]  = mk(1, 4,  0, 0, 0, 1, 0, 0);
        tv[1]  = mk(0, 0,  0, 0, 1, 1, 0, 0);
        tv[2]  = mk(0, 0,  0, 0, 1, 1, 0, 1);
        tv[3]  = mk(0, 0,  0, 0, 1, 1, 0, 2);
        tv[4]  = mk(0, 0,  0, 0, 1, 1, 0, 3);
        tv[5]  = mk(0, 0,  0, 0, 0, 1, 1, 4);
        tv[6]  = mk(0, 0,  0, 0, 0, 0, 0, 4);
        tv[7]  = mk(1, 0,  0, 0, 0, 1, 1, 0);
        tv[8]  = mk(0, 0,  0, 0, 0, 0, 0, 0);
        tv[9]  = mk(0, 0,  0, 1, 1, 0, 0, 0);
        tv[10] = mk(1, 3,  0, 1, 1, 0, 0, 0);
        tv[11] = mk(0, 0,  0, 0, 0, 0, 0, 0);
        tv[12] = mk(1, 10, 0, 0, 0, 1, 0, 0);
        tv[13] = mk(0, 0,  0, 0, 1, 1, 0, 0);
        tv[14] = mk(0, 0,  0, 0, 1, 1, 0, 1);
        tv[15] = mk(0, 0,  0, 0, 1, 1, 0, 2);
        tv[16] = mk(0, 0,  1, 0, 0, 1, 1, 3);
        tv[17] = mk(0, 0,  0, 0, 0, 0, 0, 3);
        tv[18] = mk(1, 2,  1, 0, 0, 1, 0, 0);
        tv[19] = mk(0, 0,  1, 0, 0, 1, 1, 0);
        tv[20] = mk(0, 0,  1, 0, 0, 0, 0, 0);

        rst_n = 1'b0;
        drive(0, 0, 0, 0);
        #12;
        chk("reset_clk_en", {31'd0, clk_en}, 32'd0);
        chk("reset_busy",   {31'd0, busy},   32'd0);
        chk("reset_done",   {31'd0, done},   32'd0);
        chk("reset_issued", {24'd0, issued}, 32'd0);
        rst_n = 1'b1;

        for (int k = 0; k < 21; k++) begin
            drive(tv[k].s, tv[k].n, tv[k].a, tv[k].f);
            tick();
            chk($sformatf("tv%0d_clk_en", k), {31'd0, clk_en}, {31'd0, tv[k].e});
            chk($sformatf("tv%0d_busy", k),   {31'd0, busy},   {31'd0, tv[k].b});
            chk($sformatf("tv%0d_done", k),   {31'd0, done},   {31'd0, tv[k].d});
            chk($sformatf("tv%0d_issued", k), {24'd0, issued}, 32'(tv[k].i));
        end
        drive(0, 0, 0, 0);
        tick();

        // N=4 burst: enable cycles, gated edges and a single done.
        gcount = 0;
        en_cnt = 0;
        dn_cnt = 0;
        drive(1, 4, 0, 0);
        tick();
        chk("n4_busy_first", {31'd0, busy}, 32'd1);
        drive(0, 0, 0, 0);
        for (int c = 0; c < 12; c++) begin
            tick();
            en_cnt += int'(clk_en);
            dn_cnt += int'(done);
        end
        chk("n4_en_cycles", 32'(en_cnt), 32'd4);
        chk("n4_done_cnt",  32'(dn_cnt), 32'd1);
        chk("n4_issued",    {24'd0, issued}, 32'd4);
`ifdef LOGIC_CLK_NEG_LATCH_EN
        chk("n4_gated_edges", 32'(gcount), 32'd4);
`endif

        // Start during RUN is dropped, not restarted or queued.
        en_cnt = 0;
        dn_cnt = 0;
        drive(1, 5, 0, 0);
        tick();
        drive(0, 0, 0, 0);
        tick();
        en_cnt += int'(clk_en);
        drive(1, 1, 0, 0);
        tick();
        en_cnt += int'(clk_en);
        drive(0, 0, 0, 0);
        for (int c = 0; c < 14; c++) begin
            tick();
            en_cnt += int'(clk_en);
            dn_cnt += int'(done);
        end
        chk("ign_start_en_cycles", 32'(en_cnt), 32'd5);
        chk("ign_start_done_cnt",  32'(dn_cnt), 32'd1);
        chk("ign_start_issued",    {24'd0, issued}, 32'd5);

        // Free-run for 20 cycles with a start pulse in the middle.
        iss_hold = int'(issued);
        en_cnt = 0;
        dn_cnt = 0;
        bz_cnt = 0;
        for (int c = 0; c < 20; c++) begin
            drive((c == 10), 3, 0, 1);
            tick();
            en_cnt += int'(clk_en);
            dn_cnt += int'(done);
            bz_cnt += int'(busy);
        end
        drive(0, 0, 0, 0);
        tick();
        chk("fr_en_cycles", 32'(en_cnt), 32'd20);
        chk("fr_busy_cnt",  32'(bz_cnt), 32'd0);
        chk("fr_done_cnt",  32'(dn_cnt), 32'd0);
        chk("fr_en_off",    {31'd0, clk_en}, 32'd0);
        chk("fr_issued",    {24'd0, issued}, 32'(iss_hold));

        // Reset in the middle of a burst, then a clean N=2 burst.
        drive(1, 8, 0, 0);
        tick();
        drive(0, 0, 0, 0);
        tick();
        tick();
        chk("mrst_pre_en", {31'd0, clk_en}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("mrst_clk_en", {31'd0, clk_en}, 32'd0);
        chk("mrst_busy",   {31'd0, busy},   32'd0);
        chk("mrst_done",   {31'd0, done},   32'd0);
        chk("mrst_issued", {24'd0, issued}, 32'd0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        en_cnt = 0;
        dn_cnt = 0;
        drive(1, 2, 0, 0);
        tick();
        drive(0, 0, 0, 0);
        for (int c = 0; c < 8; c++) begin
            tick();
            en_cnt += int'(clk_en);
            dn_cnt += int'(done);
        end
        chk("post_rst_en_cycles", 32'(en_cnt), 32'd2);
        chk("post_rst_done_cnt",  32'(dn_cnt), 32'd1);
        chk("post_rst_issued",    {24'd0, issued}, 32'd2);

        // Random phase against a schedule-based model, from a fresh reset.
        @(negedge clk);
        #1 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        tick();
        cur_v = 0;
        m_iss = 0;
        q.delete();
        r_f = 0;
        for (int c = 0; c < 2500; c++) begin
            if ($urandom_range(0, 39) == 0) r_f = ~r_f;
            r_s = ($urandom_range(0, 3) == 0);
            r_a = ($urandom_range(0, 11) == 0);
            r_n = ($urandom_range(0, 49) == 0) ? 255 : int'($urandom_range(0, 6));
            drive(r_s, r_n, r_a, r_f);

            if (cur_v && cur.en) m_iss++;
            if (cur_v) begin
                if (!cur.dn && r_a) begin
                    q.delete();
                    e.en = 0; e.dn = 1;
                    q.push_back(e);
                end
            end else if (r_s && !r_f) begin
                m_iss = 0;
                if (r_n > 0) begin
                    e.en = 0; e.dn = 0;
                    q.push_back(e);
                    for (int j = 0; j < r_n; j++) begin
                        e.en = 1; e.dn = 0;
                        q.push_back(e);
                    end
                end
                e.en = 0; e.dn = 1;
                q.push_back(e);
            end
            prev_idle = !cur_v;
            if (q.size() > 0) begin
                cur   = q.pop_front();
                cur_v = 1;
            end else begin
                cur_v = 0;
            end
            x_en   = cur_v ? cur.en : (prev_idle ? r_f : 1'b0);
            x_busy = cur_v;
            x_done = cur_v && cur.dn;

            tick();
            chk("rnd_clk_en", {31'd0, clk_en}, {31'd0, x_en});
            chk("rnd_busy",   {31'd0, busy},   {31'd0, x_busy});
            chk("rnd_done",   {31'd0, done},   {31'd0, x_done});
            chk("rnd_issued", {24'd0, issued}, 32'(m_iss));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
